// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// master: the requester (drives start/bin_in); slave: the converter.
interface bin2bcd_seq_if #(
    parameter int unsigned N_in  = 7,
    parameter int unsigned N_dig = 3
);
    logic                 start;
    logic [N_in-1:0]      bin_in;
    logic                 busy;
    logic                 done;
    logic [4*N_dig-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3 / double dabble).
// One input bit is consumed per cycle: a conversion takes N_in shift cycles plus
// one cycle to publish, so a result is available every N_in+1 cycles.
// Inputs above 10^N_dig-1 wrap: the bit leaving the top digit is dropped.
// Optional feature: define BIN2BCD_AUTO_EN to also start a conversion from IDLE
// whenever bin_in differs from the last accepted value.
module bin2bcd_seq #(
    parameter int unsigned N_in  = 7,
    parameter int unsigned N_dig = 3
) (
    input logic          clk,
    input logic          rst,
    bin2bcd_seq_if.slave bus
);

    localparam int unsigned BcdW = 4 * N_dig;
    localparam int unsigned CntW = $clog2(N_in + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q;
    logic [N_in-1:0]   shift_q;
    logic [BcdW-1:0]   scratch_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [BcdW-1:0]   bcd_q;

    logic [BcdW-1:0]   scratch_adj;
    logic [BcdW-1:0]   scratch_nx;
    logic [N_in-1:0]   shift_nx;
    logic              go_idle;

`ifdef BIN2BCD_AUTO_EN
    logic [N_in-1:0]   last_q;
`endif

    // Add-3 correction on every digit >= 5, then shift {scratch, shift} left by one.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < int'(N_dig); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_nx = {scratch_adj[BcdW-2:0], shift_q[N_in-1]};
        shift_nx   = shift_q << 1;
    end

    // Start condition while idle; auto mode also reacts to a changed input.
    always_comb begin
        go_idle = bus.start;
`ifdef BIN2BCD_AUTO_EN
        if (bus.bin_in != last_q) begin
            go_idle = 1'b1;
        end
`endif
    end

    // Conversion FSM with registered busy/done/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
`ifdef BIN2BCD_AUTO_EN
            last_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (go_idle) begin
                        shift_q   <= bus.bin_in;
                        scratch_q <= '0;
                        cnt_q     <= CntW'(N_in);
                        state_q   <= StShift;
`ifdef BIN2BCD_AUTO_EN
                        last_q    <= bus.bin_in;
`endif
                    end
                end
                StShift: begin
                    // busy rises on the first shift edge, one edge after acceptance
                    busy_q    <= 1'b1;
                    done_q    <= 1'b0;
                    scratch_q <= scratch_nx;
                    shift_q   <= shift_nx;
                    cnt_q     <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    bcd_q  <= scratch_q;
                    // a start here chains straight into the next conversion
                    if (bus.start) begin
                        shift_q   <= bus.bin_in;
                        scratch_q <= '0;
                        cnt_q     <= CntW'(N_in);
                        state_q   <= StShift;
`ifdef BIN2BCD_AUTO_EN
                        last_q    <= bus.bin_in;
`endif
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;

endmodule
